jkff_monitor: RTL and testbench

- Cycle-accurate checker that sits directly downstream of the JKFF cell. It taps the same clk, J, K and Q nets.
- Each cycle it predicts Q from the previous cycle's J, K and Q, compares the prediction with the live Q, and counts mismatches and toggle operations.
- It is used in-line in benches and on-chip as a self-test observer, so any JKFF instance can be checked without a reference model in the bench.

---
 rtl/jkff_monitor_if.sv | 25 ++
 rtl/jkff_monitor.sv | 97 +++++++++
 tb/tb_jkff_monitor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/jkff_monitor_if.sv
// Signal bundle between a monitored JK flip-flop tap and its checker.
// The checker sees J/K/Q plus control; everything else is checker output.
interface jkff_monitor_if #(parameter int CNT_W = 8);
  logic             en;
  logic             clr;
  logic             J;
  logic             K;
  logic             Q;
  logic             mismatch;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] toggle_cnt;
  logic [1:0]       last_op;
  logic             synced;

  modport master (
    output en, clr, J, K, Q,
    input  mismatch, err_sticky, err_cnt, toggle_cnt, last_op, synced
  );

  modport slave (
    input  en, clr, J, K, Q,
    output mismatch, err_sticky, err_cnt, toggle_cnt, last_op, synced
  );
endinterface

// File: rtl/jkff_monitor.sv
// Cycle-accurate JK flip-flop checker: predicts Q from last edge's J/K/Q,
// flags and counts mismatches, and counts toggle operations.
module jkff_monitor #(
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  jkff_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, PRIME, TRACK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             j_q, k_q, q_q;
  logic             mm_q, mm_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]       lop_q, lop_d;
  logic             exp_q;
  logic             mis;

  assign exp_q = (j_q & ~k_q) | (~j_q & ~k_q & q_q) | (j_q & k_q & ~q_q);
  // An unknown Q makes mis X; the if() below then takes the no-mismatch path.
  assign mis   = (mon.Q != exp_q);

  always_comb begin
    state_d  = state_q;
    mm_d     = 1'b0;
    sticky_d = sticky_q;
    ecnt_d   = ecnt_q;
    tcnt_d   = tcnt_q;
    lop_d    = lop_q;
    case (state_q)
      IDLE:  if (mon.en) state_d = PRIME;
      PRIME: state_d = mon.en ? TRACK : IDLE;
      TRACK: begin
        if (!mon.en) begin
          state_d = IDLE;
        end else begin
          if (mis) begin
            mm_d     = 1'b1;
            sticky_d = 1'b1;
            if (ecnt_q != CNT_MAX) ecnt_d = ecnt_q + CNT_ONE;
          end
          if (j_q && k_q && tcnt_q != CNT_MAX) tcnt_d = tcnt_q + CNT_ONE;
          lop_d = {j_q, k_q};
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear dominates any compare result; re-priming keeps stale history out.
    if (mon.clr) begin
      mm_d     = 1'b0;
      sticky_d = 1'b0;
      ecnt_d   = '0;
      tcnt_d   = '0;
      lop_d    = 2'b00;
      state_d  = mon.en ? PRIME : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      q_q      <= 1'b0;
      mm_q     <= 1'b0;
      sticky_q <= 1'b0;
      ecnt_q   <= '0;
      tcnt_q   <= '0;
      lop_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      j_q      <= mon.J;
      k_q      <= mon.K;
      q_q      <= mon.Q;
      mm_q     <= mm_d;
      sticky_q <= sticky_d;
      ecnt_q   <= ecnt_d;
      tcnt_q   <= tcnt_d;
      lop_q    <= lop_d;
    end
  end

  assign mon.mismatch   = mm_q;
  assign mon.err_sticky = sticky_q;
  assign mon.err_cnt    = ecnt_q;
  assign mon.toggle_cnt = tcnt_q;
  assign mon.last_op    = lop_q;
  assign mon.synced     = (state_q == TRACK);

endmodule

// File: tb/tb_jkff_monitor.sv
// Scoreboard bench for jkff_monitor: one stimulus stream drives an 8-bit and a
// 2-bit counter instance so saturation is exercised alongside normal counting.
module tb_jkff_monitor;
  logic gclk;
  logic grst_n;

  jkff_monitor_if #(.CNT_W(8)) if8();
  jkff_monitor_if #(.CNT_W(2)) if2();

  jkff_monitor #(.CNT_W(8)) dut8 (.clk(gclk), .rst_n(grst_n), .mon(if8));
  jkff_monitor #(.CNT_W(2)) dut2 (.clk(gclk), .rst_n(grst_n), .mon(if2));

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    logic       mm;
    logic       sticky;
    logic       synced;
    logic [1:0] lop;
    int         ec8, tc8, ec2, tc2;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  // reference model state
  int         m_st;   // 0 idle, 1 prime, 2 track
  logic       mj, mk, mq;
  logic       m_mm, m_sticky;
  logic [1:0] m_lop;
  int         m_ec8, m_tc8, m_ec2, m_tc2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic jk(input logic j, input logic k, input logic q);
    return (j & ~k) | (~j & ~k & q) | (j & k & ~q);
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_st = 0; mj = 0; mk = 0; mq = 0;
    m_mm = 0; m_sticky = 0; m_lop = 2'b00;
    m_ec8 = 0; m_tc8 = 0; m_ec2 = 0; m_tc2 = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mm8"},   32'(if8.mismatch),   0);
    chk({tag, ".stk8"},  32'(if8.err_sticky), 0);
    chk({tag, ".ec8"},   32'(if8.err_cnt),    0);
    chk({tag, ".tc8"},   32'(if8.toggle_cnt), 0);
    chk({tag, ".lop8"},  32'(if8.last_op),    0);
    chk({tag, ".syn8"},  32'(if8.synced),     0);
    chk({tag, ".mm2"},   32'(if2.mismatch),   0);
    chk({tag, ".ec2"},   32'(if2.err_cnt),    0);
    chk({tag, ".tc2"},   32'(if2.toggle_cnt), 0);
    chk({tag, ".syn2"},  32'(if2.synced),     0);
  endtask

  // mode: 0 = correct FF, 1 = Q opposite of a correct FF, 2 = Q stuck at 0
  task automatic step(input logic en, input logic clr, input logic j,
                      input logic k, input int mode);
    logic e, q;
    exp_t x;
    @(negedge gclk);
    e = jk(mj, mk, mq);
    q = (mode == 0) ? e : (mode == 1) ? ~e : 1'b0;
    if8.en = en; if8.clr = clr; if8.J = j; if8.K = k; if8.Q = q;
    if2.en = en; if2.clr = clr; if2.J = j; if2.K = k; if2.Q = q;
    if (clr) begin
      m_mm = 0; m_sticky = 0; m_lop = 2'b00;
      m_ec8 = 0; m_tc8 = 0; m_ec2 = 0; m_tc2 = 0;
      m_st = en ? 1 : 0;
    end else if (m_st == 2 && en) begin
      m_mm = (q != e);
      if (m_mm) begin
        m_sticky = 1;
        m_ec8 = sat_inc(m_ec8, 255);
        m_ec2 = sat_inc(m_ec2, 3);
      end
      if (mj && mk) begin
        m_tc8 = sat_inc(m_tc8, 255);
        m_tc2 = sat_inc(m_tc2, 3);
      end
      m_lop = {mj, mk};
    end else begin
      m_mm = 0;
      if (m_st == 0)      m_st = en ? 1 : 0;
      else if (m_st == 1) m_st = en ? 2 : 0;
      else                m_st = 0;
    end
    mj = j; mk = k; mq = q;
    x.mm = m_mm; x.sticky = m_sticky; x.synced = (m_st == 2); x.lop = m_lop;
    x.ec8 = m_ec8; x.tc8 = m_tc8; x.ec2 = m_ec2; x.tc2 = m_tc2;
    sbq.push_back(x);
    @(posedge gclk);
    #1;
    x = sbq.pop_front();
    chk("mm8",  32'(if8.mismatch),   32'(x.mm));
    chk("stk8", 32'(if8.err_sticky), 32'(x.sticky));
    chk("ec8",  32'(if8.err_cnt),    x.ec8);
    chk("tc8",  32'(if8.toggle_cnt), x.tc8);
    chk("lop8", 32'(if8.last_op),    32'(x.lop));
    chk("syn8", 32'(if8.synced),     32'(x.synced));
    chk("mm2",  32'(if2.mismatch),   32'(x.mm));
    chk("stk2", 32'(if2.err_sticky), 32'(x.sticky));
    chk("ec2",  32'(if2.err_cnt),    x.ec2);
    chk("tc2",  32'(if2.toggle_cnt), x.tc2);
    chk("lop2", 32'(if2.last_op),    32'(x.lop));
    chk("syn2", 32'(if2.synced),     32'(x.synced));
  endtask

  initial begin
    logic [1:0] op;
    grst_n = 1'b0;
    if8.en = 0; if8.clr = 0; if8.J = 0; if8.K = 0; if8.Q = 0;
    if2.en = 0; if2.clr = 0; if2.J = 0; if2.K = 0; if2.Q = 0;
    model_reset();
    @(negedge gclk);
    @(negedge gclk);
    chk_zero("rst");
    grst_n = 1'b1;

    // 1: correct FF, all four ops swept four times, plus one edge to check the last
    for (int r = 0; r < 4; r++)
      for (int o = 0; o < 4; o++) begin
        op = 2'(o);
        step(1, 0, op[1], op[0], 0);
      end
    step(1, 0, 0, 0, 0);
    chk("t1.tc8", 32'(if8.toggle_cnt), 4);
    chk("t1.tc2", 32'(if2.toggle_cnt), 3);
    chk("t1.lop", 32'(if8.last_op), 3);
    chk("t1.ec8", 32'(if8.err_cnt), 0);

    // 2: Q stuck at 0 while setting
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 2);
    chk("t2.mm", 32'(if8.mismatch), 1);
    step(1, 0, 0, 0, 0);
    chk("t2.ec8", 32'(if8.err_cnt), 3);
    chk("t2.stk", 32'(if8.err_sticky), 1);
    chk("t2.mm0", 32'(if8.mismatch), 0);

    // 3: toggle saturation, then error saturation
    step(1, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 0);
    chk("t3.tc2", 32'(if2.toggle_cnt), 3);
    chk("t3.tc8", 32'(if8.toggle_cnt), 6);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 1);
    chk("t3.ec2", 32'(if2.err_cnt), 3);
    chk("t3.ec8", 32'(if8.err_cnt), 5);
    chk("t3.tc8b", 32'(if8.toggle_cnt), 11);
    chk("t3.mm2", 32'(if2.mismatch), 1);

    // 4: clear on a mismatching edge
    step(1, 1, 1, 1, 1);
    chk("t4.ec", 32'(if8.err_cnt), 0);
    chk("t4.stk", 32'(if8.err_sticky), 0);
    chk("t4.mm", 32'(if8.mismatch), 0);
    chk("t4.syn", 32'(if8.synced), 0);
    step(1, 0, 0, 0, 1);
    chk("t4.prime_mm", 32'(if8.mismatch), 0);
    chk("t4.syn1", 32'(if8.synced), 1);
    step(1, 0, 0, 0, 1);
    chk("t4.cmp_mm", 32'(if8.mismatch), 1);

    // 5: disabled while Q wrong, then re-enable through PRIME
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
    chk("t5.ec_hold", 32'(if8.err_cnt), 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    chk("t5.no_cmp", 32'(if8.mismatch), 0);
    step(1, 0, 1, 0, 1);
    chk("t5.ec8", 32'(if8.err_cnt), 2);
    chk("t5.syn", 32'(if8.synced), 1);

    // 6: asynchronous reset between edges
    #2 grst_n = 1'b0;
    #1 chk_zero("arst");
    model_reset();
    #1 grst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    chk("t6.tc8", 32'(if8.toggle_cnt), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
